default_slave_wr: RTL

DEFAULT_SLAVE_WR -- requirements
Module: default_slave_wr

---
 rtl/default_slave_wr.sv | 138 +++++++++++++
 1 files changed

// File: rtl/default_slave_wr.sv
// Default AXI write slave: accepts any write burst, discards the data and
// answers each transaction with a fixed error response, counting completions.

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module default_slave_wr #(
  parameter logic [1:0] RESP_CODE = 2'b11
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [`AXI_IDS_BITS-1:0]   AWID,
  input  logic [`AXI_ADDR_BITS-1:0]  AWADDR,
  input  logic [`AXI_LEN_BITS-1:0]   AWLEN,
  input  logic [`AXI_SIZE_BITS-1:0]  AWSIZE,
  input  logic [1:0]                 AWBURST,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [`AXI_DATA_BITS-1:0]  WDATA,
  input  logic [`AXI_STRB_BITS-1:0]  WSTRB,
  input  logic                       WLAST,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [`AXI_IDS_BITS-1:0]   BID,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  output logic [7:0]                 ERR_CNT,
  output logic [1:0]                 fsm_state
);

  // Handshakes: a transfer on any channel happens on the rising ACLK edge
  // where both valid and ready are high; ready/valid here depend only on state.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic [`AXI_IDS_BITS-1:0]   id_q;
  logic [`AXI_LEN_BITS-1:0]   len_q;
  logic [`AXI_LEN_BITS-1:0]   beat_cnt;
  logic [7:0]                 err_cnt;
  logic                       aw_hs;
  logic                       w_hs;
  logic                       b_hs;
  logic                       last_beat;
  logic                       unused_inputs;

  assign unused_inputs = ^{AWADDR, AWSIZE, AWBURST, WDATA, WSTRB, WLAST};

  assign aw_hs     = AWVALID && AWREADY;
  assign w_hs      = WVALID && WREADY;
  assign b_hs      = BVALID && BREADY;
  assign last_beat = (beat_cnt == len_q);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // WLAST is deliberately ignored: the burst ends on the beat count alone.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (aw_hs) state_next = DATA;
      DATA:    if (w_hs && last_beat) state_next = RESP;
      RESP:    if (b_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BID     = '0;
    BRESP   = 2'b00;
    case (state)
      IDLE: AWREADY = 1'b1;
      DATA: WREADY  = 1'b1;
      RESP: begin
        BVALID = 1'b1;
        BID    = id_q;
        BRESP  = RESP_CODE;
      end
      default: AWREADY = 1'b0;
    endcase
  end

  // The counter holds on the final beat so AWLEN all-ones never wraps it.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      id_q     <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      err_cnt  <= 8'h00;
    end else begin
      if (aw_hs) begin
        id_q     <= AWID;
        len_q    <= AWLEN;
        beat_cnt <= '0;
      end
      if (w_hs && !last_beat) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (b_hs && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'h01;
      end
    end
  end

  assign ERR_CNT   = err_cnt;
  assign fsm_state = state;

endmodule
